// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one registered ALU (ADD/AND/SHL/SRA).
// Define ALU_SHARE_CARRY_EN to add the registered rsp_carry output.
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
`ifdef ALU_SHARE_CARRY_EN
  ,
  output logic             rsp_carry
`endif
);

  // state | meaning
  // IDLE  | arbitrating, readys may assert
  // EXEC  | operands latched, ALU result registered this cycle
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [WIDTH-1:0] C_WIDTH = WIDTH'(WIDTH);

  state_t           r_state;
  logic             r_rr_last;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_shift_big;
  logic [WIDTH-1:0] w_result;

  // On a tie the requester that did not win last time gets the grant.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_rr_last : req1_valid;
  assign req0_ready  = (r_state == IDLE) & w_any_valid & ~w_grant_id;
  assign req1_ready  = (r_state == IDLE) & w_any_valid & w_grant_id;
  assign w_accept    = req0_ready | req1_ready;

  assign w_sel_op = w_grant_id ? req1_op : req0_op;
  assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
  assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

`ifdef ALU_SHARE_CARRY_EN
  logic [WIDTH:0] w_sum;
  logic           w_carry;
  logic           r_rsp_carry;
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry   = (r_op == OP_ADD) & w_sum[WIDTH];
  assign rsp_carry = r_rsp_carry;
`else
  logic [WIDTH-1:0] w_sum;
  assign w_sum = r_a + r_b;
`endif

  assign w_shift_big = (r_b >= C_WIDTH);

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = w_sum[WIDTH-1:0];
      OP_AND:  w_result = r_a & r_b;
      OP_SHL:  w_result = w_shift_big ? '0 : (r_a << r_b);
      default: w_result = w_shift_big ? {WIDTH{r_a[WIDTH-1]}}
                                      : $unsigned($signed(r_a) >>> r_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_last   <= 1'b1;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
`ifdef ALU_SHARE_CARRY_EN
      r_rsp_carry <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= w_sel_op;
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_id      <= w_grant_id;
            r_rr_last <= w_grant_id;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
`ifdef ALU_SHARE_CARRY_EN
          r_rsp_carry <= w_carry;
`endif
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: arithmetic/queue reference model checked every cycle plus directed literals.
module tb_alu_share_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;
`ifdef ALU_SHARE_CARRY_EN
  logic         rsp_carry;
`endif

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef ALU_SHARE_CARRY_EN
    , .rsp_carry(rsp_carry)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic, done on plain integers rather than bit vectors.
  function automatic int model_res(input int op, input int a, input int b);
    int m, sa, p;
    m = 2 ** W;
    case (op)
      0: return (a + b) % m;
      1: return a & b;
      2: return (b >= W) ? 0 : (a * (2 ** b)) % m;
      default: begin
        sa = (a >= m / 2) ? a - m : a;
        if (b >= W) return (sa < 0) ? m - 1 : 0;
        p = 2 ** b;
        sa = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        return (sa + m) % m;
      end
    endcase
  endfunction

  function automatic int model_carry(input int op, input int a, input int b);
    return (op == 0 && (a + b) >= 2 ** W) ? 1 : 0;
  endfunction

  int q_data[$];
  int q_id[$];
  int q_carry[$];
  bit m_busy = 0;
  bit m_last = 1;
  int m_acc_cyc = 0;
  bit e0, e1, ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      q_data.delete(); q_id.delete(); q_carry.delete();
      m_busy = 0;
      m_last = 1;
    end else begin
      e0 = 0; e1 = 0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e0 = (m_last == 1);
          e1 = !e0;
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      check("mon_ready0", req0_ready, e0);
      check("mon_ready1", req1_ready, e1);
      ev = m_busy && (cyc >= m_acc_cyc + 2);
      check("mon_rsp_valid", rsp_valid, ev);
      if (rsp_valid && ev) begin
        check("mon_rsp_data", rsp_data, q_data[0]);
        check("mon_rsp_id", rsp_id, q_id[0]);
`ifdef ALU_SHARE_CARRY_EN
        check("mon_rsp_carry", rsp_carry, q_carry[0]);
`endif
        if (rsp_ready) begin
          void'(q_data.pop_front()); void'(q_id.pop_front()); void'(q_carry.pop_front());
          m_busy = 0;
        end
      end else if (!m_busy && req0_valid && req0_ready) begin
        q_data.push_back(model_res(req0_op, req0_a, req0_b));
        q_carry.push_back(model_carry(req0_op, req0_a, req0_b));
        q_id.push_back(0);
        m_busy = 1; m_last = 0; m_acc_cyc = cyc;
      end else if (!m_busy && req1_valid && req1_ready) begin
        q_data.push_back(model_res(req1_op, req1_a, req1_b));
        q_carry.push_back(model_carry(req1_op, req1_a, req1_b));
        q_id.push_back(1);
        m_busy = 1; m_last = 1; m_acc_cyc = cyc;
      end
    end
  end

  task automatic drive(input int id, input int op, input int a, input int b);
    if (id == 0) begin
      req0_op = 2'(op); req0_a = W'(a); req0_b = W'(b); req0_valid = 1'b1;
    end else begin
      req1_op = 2'(op); req1_a = W'(a); req1_b = W'(b); req1_valid = 1'b1;
    end
  endtask

  task automatic wait_ready(input int id, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) return;
    end
    check({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string name, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) return;
    end
    check({name, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic do_op(input int id, input int op, input int a, input int b,
                       input int exp, input int exp_c, input string name);
    int n;
    @(posedge clk); #1;
    drive(id, op, a, b);
    wait_ready(id, name);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(name, n);
    check({name, "_latency"}, n, 2);
    check({name, "_data"}, rsp_data, exp);
    check({name, "_id"}, rsp_id, id);
`ifdef ALU_SHARE_CARRY_EN
    check({name, "_carry"}, rsp_carry, exp_c);
`else
    if (exp_c > 1) check({name, "_carry_arg"}, exp_c, 0);
`endif
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  int grants[$];
  int rids[$];
  int exp_rr[4] = '{0, 1, 0, 1};
  int n;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(0, 0, 'hF0, 'h20, 'h10, 1, "add_f0_20");
    do_op(1, 0, 'h12, 'h34, 'h46, 0, "add_12_34");
    do_op(0, 0, 'hFF, 'h01, 'h00, 1, "add_wrap");
    do_op(1, 2, 'h81, 1,   'h02, 0, "shl_81_1");
    do_op(1, 2, 'h81, 9,   'h00, 0, "shl_b9");
    do_op(0, 2, 'h81, 8,   'h00, 0, "shl_b8");
    do_op(0, 3, 'h80, 3,   'hF0, 0, "sra_80_3");
    do_op(1, 3, 'h80, 200, 'hFF, 0, "sra_80_200");
    do_op(0, 3, 'h40, 8,   'h00, 0, "sra_pos_b8");
    do_op(1, 3, 'h7F, 7,   'h00, 0, "sra_7f_7");
    do_op(0, 1, 'hCC, 'hAA, 'h88, 0, "and_cc_aa");
    do_op(1, 1, 'h00, 'hFF, 'h00, 0, "and_00_ff");

    // Reset while the accepted op sits in EXEC; it must never come back.
    @(posedge clk); #1 drive(0, 0, 5, 6);
    wait_ready(0, "rst_mid");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_ready0", req0_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_mid_dropped", rsp_valid, 0);
    end

    // Round robin straight after reset: both valids held for four ops.
    @(posedge clk); #1;
    drive(0, 0, 1, 1);
    drive(1, 0, 3, 4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid && rsp_ready) rids.push_back(rsp_id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 20 && rids.size() < 4; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) rids.push_back(rsp_id);
    end
    check("rr_grant_count", grants.size(), 4);
    check("rr_rsp_count", rids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check($sformatf("rr_grant%0d", i), grants[i], exp_rr[i]);
      if (i < rids.size()) check($sformatf("rr_rsp_id%0d", i), rids[i], exp_rr[i]);
    end
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Backpressure with req1 waiting.
    @(posedge clk); #1 drive(0, 1, 'hF0, 'h3C);
    wait_ready(0, "bp");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1, 0, 'h10, 'h22);
    wait_rsp("bp", n);
    check("bp_data", rsp_data, 'h30);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_data", rsp_data, 'h30);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_req1_blocked", req1_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_req1_at_handshake", req1_ready, 0);
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_req1_after", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp("bp2", n);
    check("bp2_data", rsp_data, 'h32);
    check("bp2_id", rsp_id, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
